// File: rtl/track_sequencer_if.sv
// Handshake/data bundle between the track sequencer, its controller,
// the track ROM and the downstream oscillators.
interface track_sequencer_if #(
    parameter int N_CH  = 2,
    parameter int LEN_W = 12,
    parameter int CYC_W = 28
);
    logic                 start;
    logic                 stop;
    logic                 pause;
    logic                 loop_en;
    logic [LEN_W-1:0]     track_len;
    logic [CYC_W-1:0]     unit_cycles;
    logic [CYC_W-1:0]     gap_cycles;
    logic [LEN_W-1:0]     rom_addr;
    logic [8*N_CH-1:0]    rom_data;
    logic [7*N_CH-1:0]    notes;
    logic [N_CH-1:0]      gates;
    logic [LEN_W-1:0]     cur_time;
    logic                 new_time;
    logic                 busy;
    logic                 done;

    modport master (
        output start, stop, pause, loop_en,
        output track_len, unit_cycles, gap_cycles,
        output rom_data,
        input  rom_addr, notes, gates, cur_time,
        input  new_time, busy, done
    );

    modport slave (
        input  start, stop, pause, loop_en,
        input  track_len, unit_cycles, gap_cycles,
        input  rom_data,
        output rom_addr, notes, gates, cur_time,
        output new_time, busy, done
    );
endinterface

// File: rtl/track_sequencer.sv
// Multi-channel track sequencer: steps a slot index through a track ROM
// and drives per-channel notes/gates with articulation gap, pause and loop.
module track_sequencer #(
    parameter int N_CH  = 2,
    parameter int LEN_W = 12,
    parameter int CYC_W = 28
) (
    input  logic             clk,
    input  logic             rst,
    track_sequencer_if.slave bus
);
    localparam int CW1 = CYC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_GAP,
        S_PLAY
    } state_t;

    state_t            r_state;
    logic [LEN_W-1:0]  r_t;
    logic [LEN_W-1:0]  r_len;
    logic [CYC_W-1:0]  r_unit;
    logic [CYC_W-1:0]  r_gap;
    logic [CW1-1:0]    r_cnt;
    logic [8*N_CH-1:0] r_word;
    logic              r_new_time;
    logic              r_done;

    logic [CW1-1:0]    w_gap_ext;
    logic [CW1-1:0]    w_unit_ext;
    logic [CW1-1:0]    w_min_len;
    logic [CW1-1:0]    w_last;
    logic [LEN_W:0]    w_t_next;
    logic              w_more;
    logic              w_first;
    logic [8*N_CH-1:0] w_src;
    logic [7*N_CH-1:0] w_notes;
    logic [N_CH-1:0]   w_gates;

    // A slot never drops below FETCH + G gap cycles + 1 play cycle.
    assign w_gap_ext  = {1'b0, r_gap};
    assign w_unit_ext = {1'b0, r_unit};
    assign w_min_len  = w_gap_ext + CW1'(2);
    assign w_last     = ((w_unit_ext < w_min_len) ? w_min_len : w_unit_ext)
                        - CW1'(1);
    assign w_t_next   = {1'b0, r_t} + (LEN_W+1)'(1);
    assign w_more     = w_t_next < {1'b0, r_len};
    assign w_first    = (r_cnt == CW1'(1))
                        && (r_state == S_GAP || r_state == S_PLAY);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_t        <= '0;
            r_len      <= '0;
            r_unit     <= '0;
            r_gap      <= '0;
            r_cnt      <= '0;
            r_word     <= '0;
            r_new_time <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_new_time <= 1'b0;
            r_done     <= 1'b0;
            if (bus.stop) begin
                r_state <= S_IDLE;
                r_t     <= '0;
                r_cnt   <= '0;
                r_word  <= '0;
            end else begin
                // ROM word arrives one cycle after FETCH; hold it for the slot.
                if (w_first) begin
                    r_word <= bus.rom_data;
                end
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_len  <= bus.track_len;
                            r_unit <= bus.unit_cycles;
                            r_gap  <= bus.gap_cycles;
                            r_t    <= '0;
                            r_cnt  <= '0;
                            r_word <= '0;
                            if (bus.track_len == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state <= S_FETCH;
                            end
                        end
                    end
                    S_FETCH: begin
                        r_cnt      <= CW1'(1);
                        r_new_time <= 1'b1;
                        r_state    <= (r_gap == '0) ? S_PLAY : S_GAP;
                    end
                    S_GAP: begin
                        if (!bus.pause) begin
                            r_cnt <= r_cnt + CW1'(1);
                            if (r_cnt == w_gap_ext) begin
                                r_state <= S_PLAY;
                            end
                        end
                    end
                    S_PLAY: begin
                        if (!bus.pause) begin
                            if (r_cnt == w_last) begin
                                r_cnt <= '0;
                                if (w_more) begin
                                    r_t     <= r_t + LEN_W'(1);
                                    r_state <= S_FETCH;
                                end else if (bus.loop_en) begin
                                    r_t     <= '0;
                                    r_state <= S_FETCH;
                                end else begin
                                    r_t     <= '0;
                                    r_word  <= '0;
                                    r_done  <= 1'b1;
                                    r_state <= S_IDLE;
                                end
                            end else begin
                                r_cnt <= r_cnt + CW1'(1);
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // First sounding cycle shows the fresh ROM word before it is registered.
    always_comb begin
        w_src   = w_first ? bus.rom_data : r_word;
        w_notes = '0;
        w_gates = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (r_state != S_IDLE
                && !(r_state == S_GAP && !w_src[8*c+7])) begin
                w_notes[7*c +: 7] = w_src[8*c +: 7];
            end
            w_gates[c] = |w_notes[7*c +: 7];
        end
    end

    assign bus.rom_addr = r_t;
    assign bus.cur_time = r_t;
    assign bus.notes    = w_notes;
    assign bus.gates    = w_gates;
    assign bus.new_time = r_new_time;
    assign bus.done     = r_done;
    assign bus.busy     = (r_state != S_IDLE);
endmodule
